vsync_detect: RTL and testbench

Vertical timing recovery block, the receive side of the line-rate vertical sync generator. It samples an incoming active-low vsync and data-enable once per line and recovers the active-line index. It measures sync length, back porch, active lines and front porch for every frame, and declares lock once consecutive frames match. It sits at the video input, feeding line coordinates to downstream pixel logic and measured geometry to status registers.

---
 rtl/vsync_detect.sv | 243 ++++++++++++++++++++++++
 tb/tb_vsync_detect.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vsync_detect.sv
`default_nettype none
// ============================================================================
// Module      : vsync_detect
// Description : Vertical timing recovery. Samples active-low vsync and
//               data-enable once per line strobe, recovers the active-line
//               index, measures sync/back-porch/active/front-porch line counts
//               per frame and declares lock once consecutive frames match.
// Revision    : 1.0 - initial release
// ============================================================================
module vsync_detect #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_line_stb,
    input  logic       i_vsync,
    input  logic       i_vde,
    output logic [8:0] o_y,
    output logic       o_vde,
    output logic       o_frame_stb,
    output logic       o_err,
    output logic       o_locked,
    output logic [9:0] o_vsync_len,
    output logic [9:0] o_vbp,
    output logic [9:0] o_vactive,
    output logic [9:0] o_vfp
);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_SYNC   = 3'd1,
        S_BP     = 3'd2,
        S_ACTIVE = 3'd3,
        S_FP     = 3'd4
    } state_t;

    localparam logic [2:0] c_lock = 3'(LOCK_FRAMES);
    localparam logic [9:0] c_max  = 10'd1023;

    state_t     state_q, state_d;
    logic       prev_vs_q, prev_vs_d;
    logic [9:0] sync_q, sync_d;
    logic [9:0] bp_q, bp_d;
    logic [9:0] act_q, act_d;
    logic [9:0] fp_q, fp_d;
    logic [2:0] match_q, match_d;
    logic [8:0] y_q, y_d;
    logic       vde_q, vde_d;
    logic       frame_stb_q, frame_stb_d;
    logic       err_q, err_d;
    logic       locked_q, locked_d;
    logic [9:0] meas_sync_q, meas_sync_d;
    logic [9:0] meas_bp_q, meas_bp_d;
    logic [9:0] meas_act_q, meas_act_d;
    logic [9:0] meas_fp_q, meas_fp_d;

    logic       w_fall;
    logic       w_err;
    logic       w_frame_end;
    logic [9:0] w_fp_end;
    logic       w_same;

    // Next-state logic: all decisions are taken only on line-strobe cycles
    always_comb begin
        state_d     = state_q;
        prev_vs_d   = prev_vs_q;
        sync_d      = sync_q;
        bp_d        = bp_q;
        act_d       = act_q;
        fp_d        = fp_q;
        match_d     = match_q;
        y_d         = y_q;
        vde_d       = vde_q;
        frame_stb_d = 1'b0;
        err_d       = 1'b0;
        locked_d    = locked_q;
        meas_sync_d = meas_sync_q;
        meas_bp_d   = meas_bp_q;
        meas_act_d  = meas_act_q;
        meas_fp_d   = meas_fp_q;
        w_fall      = prev_vs_q & ~i_vsync;
        w_err       = 1'b0;
        w_frame_end = 1'b0;
        w_fp_end    = fp_q;
        w_same      = 1'b0;

        if (i_line_stb) begin
            prev_vs_d = i_vsync;
            vde_d     = 1'b0;

            case (state_q)
                S_HUNT: begin
                    if (w_fall) begin
                        state_d     = S_SYNC;
                        sync_d      = 10'd1;
                        frame_stb_d = 1'b1;
                    end
                end
                S_SYNC: begin
                    if ((i_vde & ~i_vsync) | w_fall) begin
                        w_err = 1'b1;
                    end else if (!i_vsync) begin
                        if (sync_q == c_max) w_err = 1'b1;
                        else                 sync_d = sync_q + 10'd1;
                    end else if (!i_vde) begin
                        state_d = S_BP;
                        bp_d    = 10'd1;
                    end else begin
                        state_d = S_ACTIVE;
                        bp_d    = 10'd0;
                        act_d   = 10'd1;
                        vde_d   = 1'b1;
                        y_d     = 9'd0;
                    end
                end
                S_BP: begin
                    if ((i_vde & ~i_vsync) | w_fall) begin
                        w_err = 1'b1;
                    end else if (i_vde) begin
                        state_d = S_ACTIVE;
                        act_d   = 10'd1;
                        vde_d   = 1'b1;
                        y_d     = 9'd0;
                    end else if (bp_q == c_max) begin
                        w_err = 1'b1;
                    end else begin
                        bp_d = bp_q + 10'd1;
                    end
                end
                S_ACTIVE: begin
                    if (i_vde & ~i_vsync) begin
                        w_err = 1'b1;
                    end else if (i_vde) begin
                        if (act_q == c_max) begin
                            w_err = 1'b1;
                        end else begin
                            act_d = act_q + 10'd1;
                            vde_d = 1'b1;
                            // Index of this line is the count before increment
                            y_d   = act_q[8:0];
                        end
                    end else if (i_vsync) begin
                        state_d = S_FP;
                        fp_d    = 10'd1;
                    end else if (w_fall) begin
                        w_frame_end = 1'b1;
                        w_fp_end    = 10'd0;
                    end
                end
                S_FP: begin
                    if (i_vde) begin
                        w_err = 1'b1;
                    end else if (i_vsync) begin
                        if (fp_q == c_max) w_err = 1'b1;
                        else               fp_d = fp_q + 10'd1;
                    end else if (w_fall) begin
                        w_frame_end = 1'b1;
                        w_fp_end    = fp_q;
                    end
                end
                default: begin
                    state_d = S_HUNT;
                end
            endcase

            if (w_frame_end) begin
                w_same      = (sync_q == meas_sync_q) && (bp_q == meas_bp_q) &&
                              (act_q == meas_act_q) && (w_fp_end == meas_fp_q);
                meas_sync_d = sync_q;
                meas_bp_d   = bp_q;
                meas_act_d  = act_q;
                meas_fp_d   = w_fp_end;
                // A zero match count marks the first frame since leaving HUNT
                if (match_q == 3'd0 || !w_same) match_d = 3'd1;
                else if (match_q == c_lock)     match_d = c_lock;
                else                            match_d = match_q + 3'd1;
                locked_d    = (match_d == c_lock);
                state_d     = S_SYNC;
                sync_d      = 10'd1;
                frame_stb_d = 1'b1;
            end

            if (w_err) begin
                state_d  = S_HUNT;
                err_d    = 1'b1;
                match_d  = 3'd0;
                locked_d = 1'b0;
                vde_d    = 1'b0;
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_HUNT;
            prev_vs_q   <= 1'b1;
            sync_q      <= 10'd0;
            bp_q        <= 10'd0;
            act_q       <= 10'd0;
            fp_q        <= 10'd0;
            match_q     <= 3'd0;
            y_q         <= 9'd0;
            vde_q       <= 1'b0;
            frame_stb_q <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            meas_sync_q <= 10'd0;
            meas_bp_q   <= 10'd0;
            meas_act_q  <= 10'd0;
            meas_fp_q   <= 10'd0;
        end else begin
            state_q     <= state_d;
            prev_vs_q   <= prev_vs_d;
            sync_q      <= sync_d;
            bp_q        <= bp_d;
            act_q       <= act_d;
            fp_q        <= fp_d;
            match_q     <= match_d;
            y_q         <= y_d;
            vde_q       <= vde_d;
            frame_stb_q <= frame_stb_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            meas_sync_q <= meas_sync_d;
            meas_bp_q   <= meas_bp_d;
            meas_act_q  <= meas_act_d;
            meas_fp_q   <= meas_fp_d;
        end
    end

    assign o_y         = y_q;
    assign o_vde       = vde_q;
    assign o_frame_stb = frame_stb_q;
    assign o_err       = err_q;
    assign o_locked    = locked_q;
    assign o_vsync_len = meas_sync_q;
    assign o_vbp       = meas_bp_q;
    assign o_vactive   = meas_act_q;
    assign o_vfp       = meas_fp_q;

endmodule
`default_nettype wire

// File: tb/tb_vsync_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vsync_detect
// Description : Self-checking bench for vsync_detect. Frames are described by
//               their geometry; expected outputs are derived per line from
//               that geometry and a frame-level lock model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vsync_detect;

    localparam int LOCK_FRAMES = 2;

    logic       clk;
    logic       rst_n;
    logic       line_stb;
    logic       vsync;
    logic       vde;
    logic [8:0] o_y;
    logic       o_vde;
    logic       o_frame_stb;
    logic       o_err;
    logic       o_locked;
    logic [9:0] o_vsync_len;
    logic [9:0] o_vbp;
    logic [9:0] o_vactive;
    logic [9:0] o_vfp;

    vsync_detect #(.LOCK_FRAMES(LOCK_FRAMES)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_line_stb  (line_stb),
        .i_vsync     (vsync),
        .i_vde       (vde),
        .o_y         (o_y),
        .o_vde       (o_vde),
        .o_frame_stb (o_frame_stb),
        .o_err       (o_err),
        .o_locked    (o_locked),
        .o_vsync_len (o_vsync_len),
        .o_vbp       (o_vbp),
        .o_vactive   (o_vactive),
        .o_vfp       (o_vfp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, kept at frame granularity
    bit          m_hunt;
    int          m_run;      // length of trailing run of identical completed frames
    logic [39:0] m_meas;     // {sync, bp, act, fp} of last completed frame
    logic [39:0] m_cur;      // geometry of the frame in progress
    int          m_y;
    bit          m_vde;
    bit          m_prev_vs;
    bit          e_stb;
    bit          e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, " frame_stb"}, 32'(o_frame_stb), 32'(e_stb));
        check({ph, " err"},       32'(o_err),       32'(e_err));
        check({ph, " vde"},       32'(o_vde),       32'(m_vde));
        check({ph, " y"},         32'(o_y),         32'(m_y));
        check({ph, " locked"},    32'(o_locked),    32'(m_run >= LOCK_FRAMES));
        check({ph, " vsync_len"}, 32'(o_vsync_len), 32'(m_meas[39:30]));
        check({ph, " vbp"},       32'(o_vbp),       32'(m_meas[29:20]));
        check({ph, " vactive"},   32'(o_vactive),   32'(m_meas[19:10]));
        check({ph, " vfp"},       32'(o_vfp),       32'(m_meas[9:0]));
    endtask

    task automatic model_reset();
        m_hunt    = 1'b1;
        m_run     = 0;
        m_meas    = '0;
        m_cur     = '0;
        m_y       = 0;
        m_vde     = 1'b0;
        m_prev_vs = 1'b1;
        e_stb     = 1'b0;
        e_err     = 1'b0;
    endtask

    task automatic model_err();
        e_err  = 1'b1;
        m_hunt = 1'b1;
        m_run  = 0;
        m_vde  = 1'b0;
    endtask

    task automatic model_frame_end();
        if (m_run == 0 || m_cur != m_meas) m_run = 1;
        else                               m_run = m_run + 1;
        m_meas = m_cur;
    endtask

    // One strobed line; returns #1 after the edge that samples it
    task automatic do_line(input logic vs_v, input logic de_v);
        vsync    = vs_v;
        vde      = de_v;
        line_stb = 1'b1;
        @(posedge clk);
        #1;
        line_stb = 1'b0;
    endtask

    // Non-strobe cycles with random input activity; outputs must hold
    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        e_stb = 1'b0;
        e_err = 1'b0;
        repeat (n) begin
            vsync = 1'($urandom);
            vde   = 1'($urandom);
            @(posedge clk);
            #1;
            check_all("hold");
        end
    endtask

    task automatic plain_line(input logic de_v, input int k, input string ph);
        e_stb = 1'b0;
        e_err = 1'b0;
        if (de_v && !m_hunt) begin
            m_vde = 1'b1;
            m_y   = k % 512;
        end else begin
            m_vde = 1'b0;
        end
        m_prev_vs = 1'b1;
        do_line(1'b1, de_v);
        check_all(ph);
        gap();
    endtask

    // Plays one frame of the given geometry; err_at injects vde on that sync line
    task automatic play_frame(input int s, input int b, input int a, input int f, input int err_at);
        bit de_v;
        bit fall;
        for (int i = 0; i < s; i++) begin
            de_v  = (i == err_at);
            fall  = m_prev_vs;
            e_stb = 1'b0;
            e_err = 1'b0;
            m_vde = 1'b0;
            if (m_hunt) begin
                if (fall) begin
                    m_hunt = 1'b0;
                    e_stb  = 1'b1;
                end
            end else if (de_v) begin
                model_err();
            end else if (fall) begin
                model_frame_end();
                e_stb = 1'b1;
            end else if (i + 1 > 1023) begin
                model_err();
            end
            m_prev_vs = 1'b0;
            do_line(1'b0, de_v);
            check_all("sync");
            gap();
        end
        for (int i = 0; i < b; i++) plain_line(1'b0, 0, "bp");
        for (int k = 0; k < a; k++) plain_line(1'b1, k, "act");
        for (int i = 0; i < f; i++) plain_line(1'b0, 0, "fp");
        if (!m_hunt) m_cur = {10'(s), 10'(b), 10'(a), 10'(f)};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, b, a, f, reps;
        rst_n    = 1'b0;
        line_stb = 1'b0;
        vsync    = 1'b1;
        vde      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_all("reset");

        // Nominal stream; lock at the third falling edge
        repeat (4) play_frame(10, 4, 272, 4, -1);
        // Geometry change drops lock, then recovers
        play_frame(10, 4, 271, 4, -1);
        repeat (3) play_frame(10, 4, 272, 4, -1);
        // No back porch, no front porch
        repeat (3) play_frame(5, 0, 40, 0, -1);
        // Active region longer than 512 lines wraps o_y
        repeat (2) play_frame(4, 2, 600, 3, -1);
        // vde during sync line, then resync
        play_frame(8, 3, 30, 3, 2);
        repeat (3) play_frame(8, 3, 30, 3, -1);
        // Sync held low past the counter range
        play_frame(1100, 2, 10, 2, -1);
        repeat (3) play_frame(3, 1, 12, 1, -1);

        // Randomized geometries, each repeated a random number of times
        for (int g = 0; g < 8; g++) begin
            s    = $urandom_range(1, 6);
            b    = $urandom_range(0, 4);
            a    = $urandom_range(1, 20);
            f    = $urandom_range(0, 4);
            reps = $urandom_range(1, 3);
            repeat (reps) play_frame(s, b, a, f, -1);
        end

        // Reset while in the active region, strobe present on that edge
        play_frame(6, 2, 30, 0, -1);
        rst_n    = 1'b0;
        vsync    = 1'b1;
        vde      = 1'b1;
        line_stb = 1'b1;
        @(posedge clk);
        #1;
        line_stb = 1'b0;
        model_reset();
        check_all("midrst");
        rst_n = 1'b1;
        repeat (4) play_frame(3, 1, 9, 2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
